register_bus_arbiter: RTL
=========================

// Module: register_bus_arbiter
//
// PURPOSE
//  Shares the register-file bus (wr / adr / bus_wr, readback bus_rd) between NREQ masters,
//  e.g. the host serial bridge and the on-chip test sequencer.
//  Sits between the masters and the bank of register_entry instances.
//  Serializes accesses with a round-robin req/ack handshake:
//  one access per grant, a one-cycle wr strobe, registered readback.
//
// PARAMETERS
//  ADRSIZE  8   register address width
//  REGSIZE  32  register data width
//  NREQ     4   number of requesters (2..8)
//
// PORTS
//  clock     in   1               system clock, all logic on posedge
//  reset_n   in   1               asynchronous active-low reset
//  req       in   NREQ            per-master request; held high until ack
//  req_wr    in   NREQ            per-master 1=write, 0=read; valid while req
//  req_adr   in   NREQ*ADRSIZE    per-master address, master i at [i*ADRSIZE +: ADRSIZE]
//  req_data  in   NREQ*REGSIZE    per-master write data, same packing
//  ack       out  NREQ            one-cycle completion pulse to the granted master
//  rd_data   out  REGSIZE         readback data, valid in the ack cycle of a read
//  wr        out  1               register bus write strobe
//  adr       out  ADRSIZE         register bus address
//  bus_wr    out  REGSIZE         register bus write data
//  bus_rd    in   REGSIZE         combinational readback mux from the register bank
//  busy      out  1               high in GRANT and ACK states
//
// BEHAVIOUR
//  - Reset (async, reset_n=0):
//    - state=IDLE, rr pointer=0
//    - ack, wr, adr, bus_wr, rd_data, busy all 0
//    - reset mid-transaction aborts it with no ack and no further wr.
//  - FSM states:
//    - IDLE: if any req, latch winner index, its req_wr, adr and data -> GRANT; else stay.
//    - GRANT (1 cycle): adr/bus_wr drive latched values; wr=1 if write, else 0.
//      Always -> ACK; capture rd_data<=bus_rd if read.
//    - ACK (1 cycle): ack[winner]=1, rd_data valid; wr=0; rr pointer <= winner+1 (mod NREQ).
//      Always -> IDLE.
//  - Latency: req sampled at edge N -> wr high cycle N+1 -> ack high cycle N+2.
//    Throughput: one access per 3 cycles.
//  - Arbitration: search starts at rr pointer, increasing index with wrap NREQ-1 -> 0;
//    the first asserted req wins.
//  - adr/bus_wr hold their last value in IDLE and ACK; only wr qualifies a write.
//  - rd_data holds until the next read completes; it is not updated on writes.
//  - Handshake rules:
//    - A master must hold req and its fields stable until ack. Fields are latched in IDLE,
//      so later changes are ignored.
//    - A req that drops before being sampled is never served.
//    - A req dropped after the grant still completes with ack.
//    - A master drops req on the edge after ack; if still high, it re-enters arbitration
//      in IDLE behind the others.
//  - Simultaneous requests from all masters are served in strict rotation, with no starvation.
//  - Single-master case: the same master is re-served every 3 cycles.
//
// CONFIGURATION
//  ARB_PRIORITY0_EN
//  - Defined: master 0 has strict priority. If req[0] is high in IDLE it wins regardless
//    of the rr pointer, and the rr pointer is not updated after a master-0 access.
//    Masters 1..NREQ-1 rotate round-robin among themselves.
//  - Undefined: pure round-robin over all NREQ masters as above.
//
// TESTING
//  1. Reset: reset_n=0 mid-GRANT of a write -> wr drops to 0 immediately;
//     ack never pulses; all outputs 0.
//  2. Single write: req[1]=1, req_wr[1]=1, adr=8'h12, data=32'hDEADBEEF
//     -> wr=1 with adr=8'h12, bus_wr=32'hDEADBEEF one cycle later; ack[1] next cycle.
//  3. Single read: req[2] read of adr 8'h05, bus_rd=32'h0000CAFE
//     -> wr stays 0; rd_data=32'h0000CAFE during ack[2] and held after.
//  4. All four req high and held continuously from reset
//     -> acks in order 0,1,2,3,0 at 3-cycle spacing.
//  5. With ARB_PRIORITY0_EN: req[0] and req[3] held high -> master 0 is served every time;
//     req[3] is served only after req[0] drops. Without the macro they alternate 0,3,0,3.
//  6. Glitch: req[1] pulsed for one cycle while busy -> no grant, no ack[1];
//     req dropped during GRANT -> ack still issued.

Source files
------------

// File: rtl/register_bus_arbiter.sv
// Round-robin arbiter sharing the register-file bus between NREQ masters: one access per grant.
// Define ARB_PRIORITY0_EN to give master 0 strict priority over the round-robin masters.
module register_bus_arbiter #(
  parameter int ADRSIZE = 8,
  parameter int REGSIZE = 32,
  parameter int NREQ    = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_wr,
  input  logic [NREQ*ADRSIZE-1:0] req_adr,
  input  logic [NREQ*REGSIZE-1:0] req_data,
  output logic [NREQ-1:0]         ack,
  output logic [REGSIZE-1:0]      rd_data,
  output logic                    wr,
  output logic [ADRSIZE-1:0]      adr,
  output logic [REGSIZE-1:0]      bus_wr,
  input  logic [REGSIZE-1:0]      bus_rd,
  output logic                    busy
);
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_e;

  state_e              state_q, state_d;
  logic [IDXW-1:0]     rr_q, rr_d;
  logic [IDXW-1:0]     win_q, win_d;
  logic                wr_lat_q, wr_lat_d;
  logic [ADRSIZE-1:0]  adr_q, adr_d;
  logic [REGSIZE-1:0]  data_q, data_d;
  logic [REGSIZE-1:0]  rd_q, rd_d;

  logic                found;
  logic [IDXW-1:0]     pick;
  logic [IDXW:0]       cand;

  // Rotating search from the rr pointer; the first asserted request wins.
  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_q} + (IDXW+1)'(k);
      if (cand >= (IDXW+1)'(NREQ)) cand = cand - (IDXW+1)'(NREQ);
      if (!found && req[cand[IDXW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDXW-1:0];
      end
    end
`ifdef ARB_PRIORITY0_EN
    if (req[0]) begin
      found = 1'b1;
      pick  = '0;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    win_d    = win_q;
    wr_lat_d = wr_lat_q;
    adr_d    = adr_q;
    data_d   = data_q;
    rd_d     = rd_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = GRANT;
        win_d   = pick;
        for (int i = 0; i < NREQ; i++) begin
          if (pick == IDXW'(i)) begin
            wr_lat_d = req_wr[i];
            adr_d    = req_adr[i*ADRSIZE +: ADRSIZE];
            data_d   = req_data[i*REGSIZE +: REGSIZE];
          end
        end
      end
      GRANT: begin
        state_d = ACK;
        if (!wr_lat_q) rd_d = bus_rd;
      end
      ACK: begin
        state_d = IDLE;
`ifdef ARB_PRIORITY0_EN
        // Master 0 accesses leave the rotation among masters 1..NREQ-1 untouched.
        if (win_q != '0)
`endif
          rr_d = (win_q == IDXW'(NREQ-1)) ? '0 : win_q + IDXW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      win_q    <= '0;
      wr_lat_q <= 1'b0;
      adr_q    <= '0;
      data_q   <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      win_q    <= win_d;
      wr_lat_q <= wr_lat_d;
      adr_q    <= adr_d;
      data_q   <= data_d;
      rd_q     <= rd_d;
    end
  end

  // Outputs decode straight from flops so reset clears the strobe immediately.
  always_comb begin
    ack = '0;
    if (state_q == ACK) ack[win_q] = 1'b1;
  end

  assign wr      = (state_q == GRANT) && wr_lat_q;
  assign busy    = (state_q != IDLE);
  assign adr     = adr_q;
  assign bus_wr  = data_q;
  assign rd_data = rd_q;

endmodule
